// File: rtl/prover_compute_mlext_fold_pkg.sv
// Shared definitions for the multilinear-extension fold block.
//   F_NBITS / Q : field element width and modulus (Mersenne prime 2^61 - 1)
//   mlext_state_t : fold controller states
//   f_add / f_sub / f_mul : canonical modular arithmetic helpers
package prover_compute_mlext_fold_pkg;

  localparam int F_NBITS = 61;
  localparam logic [F_NBITS-1:0] Q = {F_NBITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } mlext_state_t;

  // a + b mod Q, both operands canonical.
  function automatic logic [F_NBITS-1:0] f_add(input logic [F_NBITS-1:0] a,
                                               input logic [F_NBITS-1:0] b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) begin
      s = s - {1'b0, Q};
    end else begin
      s = s;
    end
    return s[F_NBITS-1:0];
  endfunction

  // m - s mod Q, formed as m + (Q - s) so no negative intermediate appears.
  function automatic logic [F_NBITS-1:0] f_sub(input logic [F_NBITS-1:0] m,
                                               input logic [F_NBITS-1:0] s);
    return f_add(m, Q - s);
  endfunction

  // a * b mod Q. Relies on Q = 2^F_NBITS - 1: the high half of the product
  // folds onto the low half because 2^F_NBITS == 1 mod Q.
  function automatic logic [F_NBITS-1:0] f_mul(input logic [F_NBITS-1:0] a,
                                               input logic [F_NBITS-1:0] b);
    logic [2*F_NBITS-1:0] p;
    logic [F_NBITS:0]     s;
    logic [F_NBITS:0]     t;
    p = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
    s = {1'b0, p[F_NBITS-1:0]} + {1'b0, p[2*F_NBITS-1:F_NBITS]};
    t = {1'b0, s[F_NBITS-1:0]} + {{F_NBITS{1'b0}}, s[F_NBITS]};
    if (t >= {1'b0, Q}) begin
      t = t - {1'b0, Q};
    end else begin
      t = t;
    end
    return t[F_NBITS-1:0];
  endfunction

endpackage

// File: rtl/prover_fold_lane.sv
// One fold lane: y = a + t*(b - a) mod Q, registered (1-cycle latency).
//   clk_i, rstb_i : clock, synchronous active-low reset
//   a_i, b_i      : even / odd element of the pair
//   t_i           : round challenge
//   y_o           : folded element, valid one cycle after a_i/b_i/t_i
module prover_fold_lane
  import prover_compute_mlext_fold_pkg::*;
(
  input  logic               clk_i,
  input  logic               rstb_i,
  input  logic [F_NBITS-1:0] a_i,
  input  logic [F_NBITS-1:0] b_i,
  input  logic [F_NBITS-1:0] t_i,
  output logic [F_NBITS-1:0] y_o
);

  logic [F_NBITS-1:0] y_q;

  // Linear interpolation between the pair, captured every cycle.
  always_ff @(posedge clk_i) begin
    if (!rstb_i) begin
      y_q <= '0;
    end else begin
      y_q <= f_add(a_i, f_mul(t_i, f_sub(b_i, a_i)));
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/prover_compute_mlext_fold.sv
// Folds an N_INPUTS-element vector to a single MLE evaluation, one variable
// (LSB first) per round, N_LANES pairs per cycle, in place.
//   clk_i, rstb_i   : clock, synchronous active-low reset
//   en_i, restart_i : start a round (restart also loads inputs_i)
//   tau_i           : round challenge, latched on acceptance
//   inputs_i        : packed vector, element i at [i*F_NBITS +: F_NBITS]
//   result_o        : buf[0]
//   round_o         : completed rounds since last restart
//   ready_o         : idle, able to accept en_i
//   ready_pulse_o   : one cycle at the end of every round
//   result_ready_o  : all rounds done, result_o valid
module prover_compute_mlext_fold
  import prover_compute_mlext_fold_pkg::*;
#(
  parameter int N_INPUTS = 16,
  parameter int N_LANES  = 2
) (
  input  logic                        clk_i,
  input  logic                        rstb_i,
  input  logic                        en_i,
  input  logic                        restart_i,
  input  logic [F_NBITS-1:0]          tau_i,
  input  logic [F_NBITS*N_INPUTS-1:0] inputs_i,
  output logic [F_NBITS-1:0]          result_o,
  output logic [$clog2($clog2(N_INPUTS)+1)-1:0] round_o,
  output logic                        ready_o,
  output logic                        ready_pulse_o,
  output logic                        result_ready_o
);

  localparam int N_ROUNDS = $clog2(N_INPUTS);
  localparam int RW       = $clog2(N_ROUNDS + 1);
  localparam int BW       = $clog2(N_INPUTS / (2 * N_LANES) + 1);
  localparam int IW       = $clog2(N_INPUTS);
  localparam int PW       = IW - 1;

  mlext_state_t       state_q, state_d;
  logic [F_NBITS-1:0] buf_q [N_INPUTS];
  logic [F_NBITS-1:0] tau_q;
  logic [RW-1:0]      round_q;
  logic [BW-1:0]      beat_q;
  logic               ready_pulse_q;
  logic               result_ready_q;
  logic [N_LANES-1:0] wb_vld_q;
  logic [PW-1:0]      wb_idx_q [N_LANES];

  logic               accept_s;
  logic               last_beat_s;
  logic [IW:0]        pairs_s;
  logic [IW:0]        base_s;
  logic [IW:0]        k_s      [N_LANES];
  logic [PW-1:0]      pk_s     [N_LANES];
  logic [N_LANES-1:0] lane_vld_s;
  logic [F_NBITS-1:0] lane_a_s [N_LANES];
  logic [F_NBITS-1:0] lane_b_s [N_LANES];
  logic [F_NBITS-1:0] lane_y_s [N_LANES];

  // A non-restart en after the last round has nothing to fold and is dropped.
  assign accept_s    = (state_q == IDLE) && en_i &&
                       (restart_i || (round_q < RW'(N_ROUNDS)));
  assign pairs_s     = (IW+1)'(N_INPUTS) >> (round_q + RW'(1));
  assign base_s      = (IW+1)'(beat_q) * (IW+1)'(N_LANES);
  assign last_beat_s = (base_s + (IW+1)'(N_LANES)) >= pairs_s;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rstb_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept_s ? RUN : IDLE;
      RUN:     state_d = last_beat_s ? DRAIN : RUN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ready_o = (state_q == IDLE);
  end

  // Lane read muxing: lane l folds pair k = beat*N_LANES + l while k < P.
  always_comb begin
    for (int l = 0; l < N_LANES; l++) begin
      k_s[l]        = base_s + (IW+1)'(l);
      pk_s[l]       = k_s[l][PW-1:0];
      lane_vld_s[l] = (state_q == RUN) && (k_s[l] < pairs_s);
      lane_a_s[l]   = buf_q[{pk_s[l], 1'b0}];
      lane_b_s[l]   = buf_q[{pk_s[l], 1'b1}];
    end
  end

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    prover_fold_lane u_lane (
      .clk_i  (clk_i),
      .rstb_i (rstb_i),
      .a_i    (lane_a_s[l]),
      .b_i    (lane_b_s[l]),
      .t_i    (tau_q),
      .y_o    (lane_y_s[l])
    );
  end

  // Round control: challenge latch, beat counter, round count, status flags,
  // and the write-back tags that follow the lane pipeline by one cycle.
  always_ff @(posedge clk_i) begin
    if (!rstb_i) begin
      tau_q          <= '0;
      round_q        <= '0;
      beat_q         <= '0;
      ready_pulse_q  <= 1'b0;
      result_ready_q <= 1'b0;
      wb_vld_q       <= '0;
      for (int l = 0; l < N_LANES; l++) wb_idx_q[l] <= '0;
    end else begin
      ready_pulse_q <= (state_q == DRAIN);
      wb_vld_q      <= lane_vld_s;
      for (int l = 0; l < N_LANES; l++) wb_idx_q[l] <= pk_s[l];
      if (accept_s) begin
        tau_q  <= tau_i;
        beat_q <= '0;
        if (restart_i) begin
          round_q        <= '0;
          result_ready_q <= 1'b0;
        end
      end else if (state_q == RUN) begin
        beat_q <= beat_q + BW'(1);
      end else if (state_q == DRAIN) begin
        round_q <= round_q + RW'(1);
        if ((round_q + RW'(1)) == RW'(N_ROUNDS)) result_ready_q <= 1'b1;
      end
    end
  end

  // Vector storage: load on restart, otherwise accept lane write-backs.
  // Writes always target indices below any later read, so in place is safe.
  always_ff @(posedge clk_i) begin
    if (!rstb_i) begin
      for (int i = 0; i < N_INPUTS; i++) buf_q[i] <= '0;
    end else if (accept_s && restart_i) begin
      for (int i = 0; i < N_INPUTS; i++) buf_q[i] <= inputs_i[i*F_NBITS +: F_NBITS];
    end else begin
      for (int l = 0; l < N_LANES; l++) begin
        if (wb_vld_q[l]) buf_q[{1'b0, wb_idx_q[l]}] <= lane_y_s[l];
      end
    end
  end

  assign result_o       = buf_q[0];
  assign round_o        = round_q;
  assign ready_pulse_o  = ready_pulse_q;
  assign result_ready_o = result_ready_q;

endmodule

// File: tb/tb_prover_compute_mlext_fold.sv
// Self-checking bench for prover_compute_mlext_fold (16 inputs, 2 lanes).
module tb_prover_compute_mlext_fold;
  import prover_compute_mlext_fold_pkg::F_NBITS;
  import prover_compute_mlext_fold_pkg::Q;

  localparam int N  = 16;
  localparam int NR = 4;
  localparam int RW = 3;
  localparam int TMO = 20;

  logic               clk = 1'b0;
  logic               rstb = 1'b0;
  logic               en = 1'b0;
  logic               restart = 1'b0;
  logic [F_NBITS-1:0] tau = '0;
  logic [F_NBITS*N-1:0] inputs = '0;
  logic [F_NBITS-1:0] result;
  logic [RW-1:0]      round;
  logic               ready, ready_pulse, result_ready;

  int errors = 0;
  int checks = 0;
  logic [F_NBITS-1:0] vec  [N];
  logic [F_NBITS-1:0] taus [NR];
  int lats [NR];

  prover_compute_mlext_fold #(.N_INPUTS(N), .N_LANES(2)) dut (
    .clk_i(clk), .rstb_i(rstb), .en_i(en), .restart_i(restart), .tau_i(tau),
    .inputs_i(inputs), .result_o(result), .round_o(round), .ready_o(ready),
    .ready_pulse_o(ready_pulse), .result_ready_o(result_ready)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: plain modular arithmetic ----------------
  function automatic logic [F_NBITS-1:0] m_mul(input logic [F_NBITS-1:0] a, input logic [F_NBITS-1:0] b);
    logic [127:0] p;
    p = ({67'd0, a} * {67'd0, b}) % {67'd0, Q};
    return p[F_NBITS-1:0];
  endfunction
  function automatic logic [F_NBITS-1:0] m_add(input logic [F_NBITS-1:0] a, input logic [F_NBITS-1:0] b);
    logic [127:0] s;
    s = ({67'd0, a} + {67'd0, b}) % {67'd0, Q};
    return s[F_NBITS-1:0];
  endfunction
  function automatic logic [F_NBITS-1:0] m_one_minus(input logic [F_NBITS-1:0] t);
    logic [127:0] s;
    s = (128'd1 + {67'd0, Q} - {67'd0, t}) % {67'd0, Q};
    return s[F_NBITS-1:0];
  endfunction
  // MLE at (taus[0..3]) with taus[r] bound to index bit r: sum vec[i]*chi_i.
  function automatic logic [F_NBITS-1:0] mle();
    logic [F_NBITS-1:0] acc, w;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      w = vec[i];
      for (int r = 0; r < NR; r++) w = m_mul(w, ((i >> r) & 1) != 0 ? taus[r] : m_one_minus(taus[r]));
      acc = m_add(acc, w);
    end
    return acc;
  endfunction
  function automatic logic [F_NBITS-1:0] rand_fe();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if (r[F_NBITS-1:0] >= Q) return r[F_NBITS-1:0] - Q;
    return r[F_NBITS-1:0];
  endfunction

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic load_inputs();
    for (int i = 0; i < N; i++) inputs[i*F_NBITS +: F_NBITS] = vec[i];
  endtask
  // Drive en for one cycle, then count cycles until ready_pulse (TMO on timeout).
  task automatic run_round(input logic rs, input logic [F_NBITS-1:0] t, output int lat);
    int n;
    en = 1'b1; restart = rs; tau = t;
    step();
    en = 1'b0; restart = 1'b0;
    n = 0;
    while (!ready_pulse && n < TMO) begin
      step();
      n++;
    end
    lat = n;
  endtask
  task automatic run_fold();
    load_inputs();
    for (int r = 0; r < NR; r++) run_round(r == 0, taus[r], lats[r]);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit saw_pulse;
    rstb = 1'b0; step(); step(); rstb = 1'b1;
    checks++;
    if (ready !== 1'b1 || ready_pulse !== 1'b0 || result_ready !== 1'b0 || round !== 3'd0 || result !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%0b pulse=%0b rr=%0b round=%0d result=%0h, required 1 0 0 0 0",
               ready, ready_pulse, result_ready, round, result);
    end
    for (int i = 0; i < N; i++) vec[i] = rand_fe();
    load_inputs();
    en = 1'b1; restart = 1'b1; tau = rand_fe();
    step();
    en = 1'b0; restart = 1'b0;
    step(); step();
    rstb = 1'b0; step(); rstb = 1'b1;
    saw_pulse = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ready_pulse) saw_pulse = 1'b1;
      step();
    end
    checks++;
    if (saw_pulse || ready !== 1'b1 || round !== 3'd0 || result !== '0 || result_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_midround: pulse_seen=%0b ready=%0b round=%0d result=%0h, required 0 1 0 0",
               saw_pulse, ready, round, result);
    end
  endtask

  task automatic test_selector();
    for (int i = 0; i < N; i++) vec[i] = rand_fe();
    for (int r = 0; r < NR; r++) taus[r] = '0;
    run_fold();
    checks++;
    if (result !== vec[0] || result_ready !== 1'b1 || round !== 3'd4) begin
      errors++;
      $display("FAIL selector_tau0: result=%0h rr=%0b round=%0d, required %0h 1 4", result, result_ready, round, vec[0]);
    end
    for (int r = 0; r < NR; r++) taus[r] = 61'd1;
    run_fold();
    checks++;
    if (result !== vec[15]) begin
      errors++;
      $display("FAIL selector_tau1: result=%0h, required %0h", result, vec[15]);
    end
  endtask

  task automatic test_linear();
    logic [F_NBITS-1:0] exp_r [NR];
    exp_r[0] = 61'd2; exp_r[1] = 61'd6; exp_r[2] = 61'd14; exp_r[3] = 61'd30;
    for (int i = 0; i < N; i++) vec[i] = F_NBITS'(i);
    load_inputs();
    for (int r = 0; r < NR; r++) begin
      run_round(r == 0, 61'd2, lats[r]);
      checks++;
      if (result !== exp_r[r]) begin
        errors++;
        $display("FAIL linear_round%0d: buf0=%0d, required %0d", r, result, exp_r[r]);
      end
    end
    for (int i = 0; i < N; i++) vec[i] = 61'd5;
    for (int r = 0; r < NR; r++) taus[r] = rand_fe();
    run_fold();
    checks++;
    if (result !== 61'd5) begin
      errors++;
      $display("FAIL constant_vec: result=%0h, required 5", result);
    end
  endtask

  task automatic test_latency();
    int exp_lat [NR];
    exp_lat[0] = 5; exp_lat[1] = 3; exp_lat[2] = 2; exp_lat[3] = 2;
    for (int i = 0; i < N; i++) vec[i] = rand_fe();
    for (int r = 0; r < NR; r++) taus[r] = rand_fe();
    load_inputs();
    for (int r = 0; r < NR; r++) begin
      run_round(r == 0, taus[r], lats[r]);
      checks++;
      if (lats[r] != exp_lat[r] || round !== RW'(r + 1) || ready !== 1'b1) begin
        errors++;
        $display("FAIL latency_round%0d: lat=%0d round=%0d ready=%0b, required %0d %0d 1",
                 r, lats[r], round, ready, exp_lat[r], r + 1);
      end
    end
    checks++;
    if (result !== mle()) begin
      errors++;
      $display("FAIL latency_result: result=%0h, required %0h", result, mle());
    end
  endtask

  task automatic test_misuse();
    int n;
    bit bad;
    logic [F_NBITS-1:0] saved;
    for (int i = 0; i < N; i++) vec[i] = rand_fe();
    for (int r = 0; r < NR; r++) taus[r] = rand_fe();
    load_inputs();
    en = 1'b1; restart = 1'b1; tau = taus[0];
    step();
    restart = 1'b0; tau = rand_fe();
    step(); step();
    en = 1'b0;
    n = 0;
    while (!ready_pulse && n < TMO) begin step(); n++; end
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ready_pulse || !ready || round !== 3'd1) bad = 1'b1;
    end
    checks++;
    if (n >= TMO || bad) begin
      errors++;
      $display("FAIL busy_en_ignored: wait=%0d extra_activity=%0b round=%0d, required <%0d 0 1", n, bad, round, TMO);
    end
    for (int r = 1; r < NR; r++) run_round(1'b0, taus[r], lats[r]);
    saved = mle();
    checks++;
    if (result !== saved || result_ready !== 1'b1 || round !== 3'd4) begin
      errors++;
      $display("FAIL busy_result: result=%0h rr=%0b round=%0d, required %0h 1 4", result, result_ready, round, saved);
    end
    en = 1'b1; restart = 1'b0; tau = rand_fe();
    step();
    en = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ready_pulse || !ready || !result_ready || round !== 3'd4 || result !== saved) bad = 1'b1;
      step();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL en_after_done: disturbed=1 rr=%0b round=%0d result=%0h, required 1 4 %0h",
               result_ready, round, result, saved);
    end
    for (int i = 0; i < N; i++) vec[i] = rand_fe();
    load_inputs();
    en = 1'b1; restart = 1'b1; tau = taus[0];
    step();
    en = 1'b0; restart = 1'b0;
    checks++;
    if (result_ready !== 1'b0 || round !== 3'd0) begin
      errors++;
      $display("FAIL restart_clears: rr=%0b round=%0d, required 0 0", result_ready, round);
    end
    n = 0;
    while (!ready_pulse && n < TMO) begin step(); n++; end
    for (int r = 1; r < NR; r++) run_round(1'b0, taus[r], lats[r]);
    checks++;
    if (result !== mle() || result_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_result: result=%0h rr=%0b, required %0h 1", result, result_ready, mle());
    end
  endtask

  task automatic test_random();
    logic [F_NBITS-1:0] exp_v;
    for (int trip = 0; trip < 8; trip++) begin
      for (int i = 0; i < N; i++) vec[i] = rand_fe();
      for (int r = 0; r < NR; r++) taus[r] = rand_fe();
      // Keep some boundary values in play: 0 and Q-1 as taus/inputs.
      if (trip == 1) begin taus[0] = Q - 61'd1; vec[3] = Q - 61'd1; end
      if (trip == 2) begin taus[2] = '0; vec[0] = '0; end
      run_fold();
      exp_v = mle();
      checks++;
      if (result !== exp_v || result_ready !== 1'b1) begin
        errors++;
        $display("FAIL random_trip%0d: result=%0h rr=%0b, required %0h 1", trip, result, result_ready, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_selector();
    test_linear();
    test_latency();
    test_misuse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
